// File: rtl/pixel_out_fifo.sv
// First-word fall-through pixel FIFO at the end of the filter chain.
// Buffers {sof, r, g, b} pixels behind a valid/ready handshake and flags drops with a sticky overflow bit.
module pixel_out_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    r_in,
  input  logic [7:0]    g_in,
  input  logic [7:0]    b_in,
  input  logic          sof_in,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    r_out,
  output logic [7:0]    g_out,
  output logic [7:0]    b_out,
  output logic          sof_out,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clr_ovf
);

  typedef struct packed {
    logic       sof;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  pix_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic w_push;
  logic w_pop;
  logic w_drop;
  pix_t w_head;

  // in_ready looks only at occupancy so a full FIFO never passes a pixel straight through
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_drop    = in_valid & ~in_ready;

  assign w_head   = r_mem[r_rd_ptr];
  assign sof_out  = w_head.sof;
  assign r_out    = w_head.r;
  assign g_out    = w_head.g;
  assign b_out    = w_head.b;
  assign level    = r_count;
  assign overflow = r_ovf;

  // Storage is not reset; entries are only observable once counted in
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{sof: sof_in, r: r_in, g: g_in, b: b_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new drop outranks a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_pixel_out_fifo.sv
// Directed table plus scoreboard-driven sequences for pixel_out_fifo.
module tb_pixel_out_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
  logic        sof_in = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  r_out, g_out, b_out;
  logic        sof_out;
  logic        out_ready = 1'b0;
  logic [AW:0] level;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  pixel_out_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .sof_in(sof_in), .in_ready(in_ready), .out_valid(out_valid), .r_out(r_out),
    .g_out(g_out), .b_out(b_out), .sof_out(sof_out), .out_ready(out_ready),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [24:0] q[$];
  logic        m_ovf;

  function automatic logic [24:0] out_px();
    return {sof_out, r_out, g_out, b_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [24:0] px, input logic ordy, input logic clr);
    in_valid = iv;
    {sof_in, r_in, g_in, b_in} = px;
    out_ready = ordy;
    clr_ovf = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks current outputs against the queue model, then clocks and advances the model
  task automatic mcycle(input logic iv, input logic [24:0] px, input logic ordy, input logic clr);
    logic push, pop, full;
    drive(iv, px, ordy, clr);
    #1;
    full = (q.size() == DEPTH);
    chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("m_in_ready", 32'(in_ready), 32'(!full));
    chk("m_level", 32'(level), 32'(q.size()));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) chk("m_head", 32'(out_px()), 32'(q[0]));
    push = iv && !full;
    pop  = ordy && (q.size() != 0);
    step();
    if (pop) void'(q.pop_front());
    if (push) q.push_back(px);
    if (iv && full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [24:0] px;
    logic        ordy;
    logic        clr;
    logic        e_ov;
    logic        e_ir;
    logic [4:0]  e_lvl;
    logic        e_ovf;
    logic        chk_px;
    logic [24:0] e_px;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [24:0] held;
    int seq;

    tbl[0] = '{1'b1, 25'h1123456, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 25'h1123456};
    tbl[1] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 25'h0};
    tbl[2] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 25'h0};
    tbl[3] = '{1'b1, 25'h0010203, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 25'h0010203};
    tbl[4] = '{1'b1, 25'h1040506, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 25'h0010203};
    tbl[5] = '{1'b1, 25'h0070809, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 25'h1040506};
    tbl[6] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 25'h0070809};
    tbl[7] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 25'h0};

    // Async reset mid-cycle, observed before any clock edge
    #3 rst = 1'b1;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    chk("idle_level", 32'(level), 32'd0);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].iv, tbl[i].px, tbl[i].ordy, tbl[i].clr);
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].e_lvl));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
      if (tbl[i].chk_px) chk($sformatf("v%0d_pixel", i), 32'(out_px()), 32'(tbl[i].e_px));
    end
    drive(1'b0, 25'h0, 1'b0, 1'b0);

    // Fill to full with r = 0..15
    q = {};
    m_ovf = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      mcycle(1'b1, {(i == 0), 8'(i), 8'(i + 8'h40), 8'(i + 8'h80)}, 1'b0, 1'b0);
    #1;
    chk("full_level", 32'(level), 32'd16);
    chk("full_in_ready", 32'(in_ready), 32'd0);

    // Offer 0xAA while full, even with out_ready high
    drive(1'b1, {1'b0, 8'hAA, 8'hAA, 8'hAA}, 1'b1, 1'b0);
    #1 chk("full_ordy_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, {1'b0, 8'hAA, 8'hAA, 8'hAA}, 1'b0, 1'b0);
    step();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    drive(1'b1, {1'b0, 8'hAA, 8'hAA, 8'hAA}, 1'b0, 1'b1);
    step();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    drive(1'b0, 25'h0, 1'b0, 1'b1);
    step();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("ovf_level2", 32'(level), 32'd16);

    // Drain in order; in_ready returns after the first pop
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 25'h0, 1'b1, 1'b0);
      #1;
      chk("drain_r", 32'(r_out), 32'(i));
      chk("drain_sof", 32'(sof_out), 32'(i == 0));
      step();
      if (i == 0) chk("drain_in_ready", 32'(in_ready), 32'd1);
    end
    chk("drain_level", 32'(level), 32'd0);
    drive(1'b0, 25'h0, 1'b0, 1'b0);

    // Level 5 then 100 cycles of simultaneous push/pop across pointer wrap
    q = {};
    m_ovf = 1'b0;
    seq = 0;
    for (int i = 0; i < 5; i++) begin
      mcycle(1'b1, {1'b0, 8'(seq), 8'(seq >> 8), 8'hC3}, 1'b0, 1'b0);
      seq++;
    end
    for (int i = 0; i < 100; i++) begin
      mcycle(1'b1, {(seq % 7 == 0), 8'(seq), 8'(seq >> 8), 8'hC3}, 1'b1, 1'b0);
      seq++;
    end
    chk("pp_level", 32'(level), 32'd5);

    // Random backpressure with stall-stability check
    for (int i = 0; i < 10000; i++) begin
      logic iv, ordy, clr;
      iv   = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < 55);
      clr  = ($urandom_range(0, 99) < 3);
      held = out_px();
      if (i > 0 && out_valid && !out_ready) begin
        #1 chk("stall_stable", 32'(out_px()), 32'(held));
      end
      mcycle(iv, 25'($urandom()), ordy, clr);
    end

    // Reset mid-stream discards contents immediately
    drive(1'b1, 25'h1ABCDEF, 1'b0, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    drive(1'b0, 25'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_out_fifo.md
# pixel_out_fifo

Receiving end of the filter chain. Accepts filtered RGB pixels (with start-of-frame tag) from any 1-cycle-latency filter stage (invert, grayscale, etc.) and buffers them in a small FIFO. Presents them to the display/capture side through a valid/ready handshake. Decouples filter throughput from downstream stalls and flags any pixel dropped because the buffer was full.

## Interface
- DEPTH, 16, number of pixel entries; power of two, 4..256
- AW, 4, log2(DEPTH); pointer width
- clk  input  1  pixel clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream pixel present this cycle
- r_in, g_in, b_in  input  8 each  filtered pixel components
- sof_in  input  1  pixel is first of frame
- in_ready  output  1  FIFO can accept a pixel this cycle
- out_valid  output  1  out_* hold a valid pixel
- r_out, g_out, b_out  output  8 each  head-of-FIFO pixel
- sof_out  output  1  sof tag of head pixel
- out_ready  input  1  downstream consumes head pixel this cycle
- level  output  AW+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a pixel was offered while full
- clr_ovf  input  1  synchronous clear of overflow

## Operation
- Storage: DEPTH x 25-bit entries {sof, r, g, b}; wr_ptr, rd_ptr are AW bits and wrap modulo DEPTH; occupancy counter count is AW+1 bits.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH), combinational from count only (never from out_ready).
- out_valid = (count != 0); out_* = mem[rd_ptr] (first-word fall-through).
- On push: mem[wr_ptr] <= {sof_in, r_in, g_in, b_in}; wr_ptr <= wr_ptr + 1.
- On pop: rd_ptr <= rd_ptr + 1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- level = count.
- Full and out_ready=1: in_ready stays 0 that cycle. No same-cycle pass-through push.
- Empty: out_valid=0. out_ready is ignored, with no pointer change and no underflow.
- Overflow: in_valid=1 while in_ready=0 sets overflow on the next edge. The offered pixel is dropped and no state other than overflow changes.
- clr_ovf=1 clears overflow on the next edge. If a set condition coincides with clr_ovf, set wins.
- Data is carried bit-exact. No arithmetic is done on pixel values.
- Downstream must hold out_ready semantics only. It may deassert at any time, and out_* stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset (async assert, released synchronously to clk by the top level):
  - wr_ptr=0, rd_ptr=0, count=0
  - out_valid=0, in_ready=1, level=0, overflow=0
  - r_out/g_out/b_out/sof_out are don't-care while out_valid=0
- Reset mid-stream discards all buffered pixels immediately, with no drain.
- Latency: a push at edge N into an empty FIFO gives out_valid=1 with that pixel on out_* after edge N (one cycle).
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- in_ready falls after the edge that makes count=DEPTH. It rises after the first pop edge from full.
- level updates on the same edge as the pointers.

## Test plan
- Reset then idle:
  - Stimulus: rst pulse mid-cycle (async), then no traffic.
  - Required: immediately level=0, out_valid=0, in_ready=1, overflow=0.
- Single pixel:
  - Stimulus: push {sof=1, 0x12, 0x34, 0x56} at edge 1, out_ready=1.
  - Required: out_valid=1 with exactly that pixel after edge 1; popped at edge 2; level 0 after edge 2.
- Fill to full (DEPTH=16, out_ready=0):
  - Stimulus: push pixels r=0..15.
  - Required: level=16, in_ready=0.
  - Then raise out_ready: pixels emerge in order 0..15, and in_ready=1 after the first pop.
- Simultaneous push/pop:
  - Stimulus: at level=5, in_valid=1 and out_ready=1 for 100 cycles.
  - Required: level stays 5, output order equals input order, pointers wrap past 15 correctly.
- Overflow:
  - Stimulus: at full, in_valid=1 with r=0xAA.
  - Required: overflow=1 next cycle, 0xAA never appears at output, level stays 16.
  - clr_ovf pulse clears it; clr_ovf in the same cycle as a new overflow leaves it at 1.
- Random backpressure:
  - Stimulus: random in_valid/out_ready for 10k cycles against a scoreboard.
  - Required: no loss or duplication when no overflow occurs, sof tags aligned with their pixels, out_* stable during a stall.
